// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // An access is rejected when misaligned, out of range, or both read and write are requested.
  function automatic logic access_error(input logic [31:0] addr,
                                        input logic        rd,
                                        input logic        wr,
                                        input int          depth);
    logic misaligned;
    logic out_of_range;
    logic conflict;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr >= 32'(depth * 4));
    conflict     = rd & wr;
    return misaligned | out_of_range | conflict;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and a registered read port.
// The read register doubles as the responder's load-data output, so it can
// be cleared (error response) and reset, while the storage itself never resets.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: cleared on reset or error response, loaded on a good load, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {WORD_W{1'b0}};
    end else if (clr) begin
      rdata <= {WORD_W{1'b0}};
    end else if (re) begin
      rdata <= mem[idx];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory port. Serves one word
// load/store at a time with a fixed latency, stalling the CPU meanwhile.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_rd;
  logic                lat_wr;
  logic                lat_err;
  logic [ADDR_W-1:0]   lat_idx;
  logic [WORD_W-1:0]   lat_data;
  logic                ack_r;
  logic                err_r;

  logic                req;
  logic                req_err;
  logic                commit;
  logic                op_rd;
  logic                op_wr;
  logic                op_err;
  logic [ADDR_W-1:0]   op_idx;
  logic [WORD_W-1:0]   op_data;
  logic                arr_we;
  logic                arr_re;
  logic                arr_clr;

  assign req     = MemRead_i | MemWrite_i;
  assign req_err = access_error(addr_i, MemRead_i, MemWrite_i, DEPTH);

  // Select the operation that commits on the edge entering DONE: live inputs
  // when a single-cycle access goes straight from IDLE, the latched copy otherwise.
  always_comb begin
    commit  = 1'b0;
    op_rd   = lat_rd;
    op_wr   = lat_wr;
    op_err  = lat_err;
    op_idx  = lat_idx;
    op_data = lat_data;
    case (state)
      IDLE: begin
        commit  = req & (LATENCY == 1);
        op_rd   = MemRead_i;
        op_wr   = MemWrite_i;
        op_err  = req_err;
        op_idx  = addr_i[ADDR_W+1:2];
        op_data = data_i;
      end
      BUSY: begin
        commit = (cnt == CNT_ONE);
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

  // Pipeline hold: a fresh request or an access in flight; released in the ack cycle.
  always_comb begin
    if (state == IDLE) begin
      stall_o = req;
    end else if (state == BUSY) begin
      stall_o = 1'b1;
    end else begin
      stall_o = 1'b0;
    end
  end

  // Array controls; reset aborts the commit so a pending store is dropped.
  assign arr_we  = commit & op_wr & ~op_err & ~rst_i;
  assign arr_re  = commit & op_rd & ~op_err & ~rst_i;
  assign arr_clr = commit & op_err & ~rst_i;

  // Access FSM with latency counter, request latch and registered ack/err.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_err  <= 1'b0;
      lat_idx  <= {ADDR_W{1'b0}};
      lat_data <= {WORD_W{1'b0}};
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      ack_r <= commit;
      err_r <= commit & op_err;
      case (state)
        IDLE: begin
          if (req) begin
            lat_rd   <= MemRead_i;
            lat_wr   <= MemWrite_i;
            lat_err  <= req_err;
            lat_idx  <= addr_i[ADDR_W+1:2];
            lat_data <= data_i;
            cnt      <= CNT_INIT;
            state    <= (LATENCY > 1) ? BUSY : DONE;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ack_o = ack_r;
  assign err_o = err_r;

  dmem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk_i),
    .rst  (rst_i),
    .we   (arr_we),
    .re   (arr_re),
    .clr  (arr_clr),
    .idx  (op_idx),
    .wdata(op_data),
    .rdata(data_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=3 and LATENCY=1 builds).
module tb_dmem_responder;

  logic        clk = 1'b0;
  // LATENCY=3 instance
  logic        rst, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        stall, ack, err;
  // LATENCY=1 instance
  logic        rst1, rd1, wr1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        stall1, ack1, err1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .data_o(rdata),
    .stall_o(stall), .ack_o(ack), .err_o(err)
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .data_i(wdata1), .data_o(rdata1),
    .stall_o(stall1), .ack_o(ack1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access on the LATENCY=3 instance, checking every cycle.
  task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic chk_data, input logic [31:0] exp_data,
                     input string tag);
    rd = r; wr = w; addr = a; wdata = d;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_noack"}, {31'd0, ack}, 32'd0);
      @(posedge clk); #1;
    end
    #1;
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    chk({tag, "_ackstall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    if (chk_data) chk({tag, "_data"}, rdata, exp_data);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    #1;
    chk({tag, "_ackdrop"}, {31'd0, ack}, 32'd0);
    chk({tag, "_errdrop"}, {31'd0, err}, 32'd0);
    if (chk_data) chk({tag, "_hold"}, rdata, exp_data);
  endtask

  // One access on the LATENCY=1 instance; the next request may follow immediately.
  task automatic acc1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic chk_data, input logic [31:0] exp_data, input string tag);
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    #1;
    chk({tag, "_stall"}, {31'd0, stall1}, 32'd1);
    chk({tag, "_noack"}, {31'd0, ack1}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_ack"}, {31'd0, ack1}, 32'd1);
    chk({tag, "_ackstall"}, {31'd0, stall1}, 32'd0);
    chk({tag, "_err"}, {31'd0, err1}, 32'd0);
    if (chk_data) chk({tag, "_data"}, rdata1, exp_data);
    @(posedge clk); #1;
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; rst1 = 1'b0;

    // 1. idle after reset
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("idle_ack", {31'd0, ack}, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_data", rdata, 32'd0);
    end
    chk("idle1_stall", {31'd0, stall1}, 32'd0);
    chk("idle1_ack", {31'd0, ack1}, 32'd0);

    // 2. store then load, store leaves data_o alone
    acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, "st10");
    acc(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF, "ld10");
    acc(1'b0, 1'b1, 32'h14, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF, "st14");
    acc(1'b1, 1'b0, 32'h14, 32'd0, 1'b0, 1'b1, 32'h12345678, "ld14");

    // 4. error cases
    acc(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0, "st00");
    acc(1'b1, 1'b0, 32'h6, 32'd0, 1'b1, 1'b1, 32'd0, "ld_mis");
    acc(1'b1, 1'b0, 32'h14, 32'd0, 1'b0, 1'b1, 32'h12345678, "ld14b");
    acc(1'b0, 1'b1, 32'h80, 32'hFFFF0000, 1'b1, 1'b1, 32'd0, "st_oor");
    acc(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 32'hA5A5A5A5, "ld00");
    acc(1'b1, 1'b1, 32'h0, 32'h77777777, 1'b1, 1'b1, 32'd0, "rdwr");
    acc(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 32'hA5A5A5A5, "ld00b");

    // 5. reset mid-operation aborts the store
    acc(1'b0, 1'b1, 32'h8, 32'h11111111, 1'b0, 1'b0, 32'd0, "st08");
    rd = 1'b0; wr = 1'b1; addr = 32'h8; wdata = 32'h00000055;
    #1; chk("rst_stall0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_noack", {31'd0, ack}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    @(posedge clk); #1;
    chk("rst_noack2", {31'd0, ack}, 32'd0);
    acc(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 1'b1, 32'h11111111, "ld08");

    // 6. inputs changing during BUSY are ignored
    acc(1'b0, 1'b1, 32'hC, 32'hCCCCCCCC, 1'b0, 1'b0, 32'd0, "st0c");
    rd = 1'b0; wr = 1'b1; addr = 32'h4; wdata = 32'h44444444;
    @(posedge clk); #1;
    addr = 32'hC; wdata = 32'hBBBBBBBB;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("chg_ack", {31'd0, ack}, 32'd1);
    chk("chg_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    wr = 1'b0;
    acc(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b1, 32'h44444444, "ld04");
    acc(1'b1, 1'b0, 32'hC, 32'd0, 1'b0, 1'b1, 32'hCCCCCCCC, "ld0c");

    // 3. LATENCY=1: preload, then back-to-back loads (acks in cycles 1 and 3)
    acc1(1'b0, 1'b1, 32'h0, 32'h0A0A0A0A, 1'b0, 32'd0, "l1_st0");
    acc1(1'b0, 1'b1, 32'h4, 32'h0B0B0B0B, 1'b0, 32'd0, "l1_st4");
    acc1(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 32'h0A0A0A0A, "l1_ld0");
    acc1(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 32'h0B0B0B0B, "l1_ld4");
    #1;
    chk("l1_idle_ack", {31'd0, ack1}, 32'd0);
    chk("l1_idle_stall", {31'd0, stall1}, 32'd0);
    chk("l1_hold", rdata1, 32'h0B0B0B0B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
